// File: rtl/memory_blank_verify_if.sv
// SRAM-port and sequencer signals for the blank-verify checker.
// The checker sits on the master side. The sequencer, SRAM model or testbench sits on the slave side.
interface memory_blank_verify_if #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = ADDR_WIDTH
);
  logic                   enable;
  logic                   pause;
  logic [DATA_WIDTH-1:0]  data_read;
  logic                   wren;
  logic [ADDR_WIDTH-1:0]  address;
  logic                   done;
  logic                   pass;
  logic [COUNT_WIDTH-1:0] error_count;
  logic [ADDR_WIDTH-1:0]  first_error_address;
  logic [DATA_WIDTH-1:0]  first_error_data;

  modport master (
    input  enable,
    input  pause,
    input  data_read,
    output wren,
    output address,
    output done,
    output pass,
    output error_count,
    output first_error_address,
    output first_error_data
  );

  modport slave (
    output enable,
    output pause,
    output data_read,
    input  wren,
    input  address,
    input  done,
    input  pass,
    input  error_count,
    input  first_error_address,
    input  first_error_data
  );
endinterface

// File: rtl/memory_blank_verify.sv
// Readback checker run after SRAM blanking: reads 0..LAST_ADDRESS in order, compares every word
// against the fill pattern, counts mismatches, records the first failure and reports done/pass.
module memory_blank_verify #(
  parameter int                    ADDR_WIDTH   = 18,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = 32'h7755_3311,
  parameter int unsigned           LAST_ADDRESS = 262141,
  parameter int                    READ_LATENCY = 2,
  parameter int                    COUNT_WIDTH  = ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  memory_blank_verify_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(LAST_ADDRESS);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [ADDR_WIDTH-1:0]   address_r;
  logic [READ_LATENCY-1:0] valid_r;
  logic [ADDR_WIDTH-1:0]   tag_r [READ_LATENCY];
  logic                    done_r;
  logic                    pass_r;
  logic [COUNT_WIDTH-1:0]  err_cnt_r;
  logic [ADDR_WIDTH-1:0]   first_addr_r;
  logic [DATA_WIDTH-1:0]   first_data_r;

  logic                    issue_s;
  logic                    retire_s;
  logic                    mismatch_s;
  logic                    first_hit_s;
  logic                    drained_s;
  logic [COUNT_WIDTH-1:0]  err_cnt_next_s;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    if (value == COUNT_MAX) begin
      return value;
    end else begin
      return value + COUNT_WIDTH'(1'b1);
    end
  endfunction

  // Empty after this edge when only the oldest stage may still hold a token.
  function automatic logic only_tail_valid(input logic [READ_LATENCY-1:0] valid);
    logic [READ_LATENCY-1:0] mask;
    mask                 = {READ_LATENCY{1'b1}};
    mask[READ_LATENCY-1] = 1'b0;
    return (valid & mask) == {READ_LATENCY{1'b0}};
  endfunction

  // Per-edge issue/retire/compare decisions; pause freezes all of them.
  always_comb begin
    issue_s     = (state_r == ISSUE) && !bus.pause;
    retire_s    = valid_r[READ_LATENCY-1] && !bus.pause;
    mismatch_s  = retire_s && (bus.data_read != PATTERN);
    first_hit_s = mismatch_s && (err_cnt_r == {COUNT_WIDTH{1'b0}});
    if (mismatch_s) begin
      err_cnt_next_s = sat_inc(err_cnt_r);
    end else begin
      err_cnt_next_s = err_cnt_r;
    end
    drained_s = (state_r == DRAIN) && !bus.pause && only_tail_valid(valid_r);
  end

  // Sequencer FSM, read-token pipeline and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= {ADDR_WIDTH{1'b0}};
      address_r    <= {ADDR_WIDTH{1'b0}};
      valid_r      <= {READ_LATENCY{1'b0}};
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= {COUNT_WIDTH{1'b0}};
      first_addr_r <= {ADDR_WIDTH{1'b0}};
      first_data_r <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (!bus.enable) begin
      // Abort: discard in-flight reads so a later enable restarts cleanly at address 0.
      state_r      <= IDLE;
      cnt_r        <= {ADDR_WIDTH{1'b0}};
      address_r    <= {ADDR_WIDTH{1'b0}};
      valid_r      <= {READ_LATENCY{1'b0}};
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_cnt_r    <= {COUNT_WIDTH{1'b0}};
      first_addr_r <= {ADDR_WIDTH{1'b0}};
      first_data_r <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      if (!bus.pause) begin
        for (int i = READ_LATENCY - 1; i > 0; i--) begin
          valid_r[i] <= valid_r[i-1];
          tag_r[i]   <= tag_r[i-1];
        end
        valid_r[0] <= issue_s;
        tag_r[0]   <= cnt_r;
      end

      err_cnt_r <= err_cnt_next_s;
      if (first_hit_s) begin
        first_addr_r <= tag_r[READ_LATENCY-1];
        first_data_r <= bus.data_read;
      end

      case (state_r)
        IDLE: begin
          state_r <= ISSUE;
        end
        ISSUE: begin
          if (issue_s) begin
            address_r <= cnt_r;
            if (cnt_r == LAST_ADDR) begin
              state_r <= DRAIN;
            end else begin
              cnt_r <= cnt_r + ADDR_WIDTH'(1'b1);
            end
          end
        end
        DRAIN: begin
          // The final compare lands on this same edge, so pass uses the updated count.
          if (drained_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            pass_r  <= (err_cnt_next_s == {COUNT_WIDTH{1'b0}});
          end
        end
        DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.wren                = 1'b0;
  assign bus.address             = address_r;
  assign bus.done                = done_r;
  assign bus.pass                = pass_r;
  assign bus.error_count         = err_cnt_r;
  assign bus.first_error_address = first_addr_r;
  assign bus.first_error_data    = first_data_r;

endmodule

// File: tb/tb_memory_blank_verify.sv
// Self-checking bench for memory_blank_verify. It uses a scoreboard of expected read addresses
// and of expected end-of-run results, against a latency-2 SRAM model.
module tb_memory_blank_verify;
  localparam int          AW      = 18;
  localparam int          DW      = 32;
  localparam int          LAST    = 1100;
  localparam logic [31:0] PAT     = 32'h7755_3311;
  localparam int          ERR_MAX = (1 << AW) - 1;

  typedef struct {
    int          cycles;
    int          err;
    int          fea;
    logic [31:0] fed;
    bit          pass;
  } res_t;

  logic clk;
  logic reset;

  memory_blank_verify_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(AW)) bus ();
  memory_blank_verify_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(2))  sat_bus ();

  memory_blank_verify #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(PAT),
    .LAST_ADDRESS(LAST), .READ_LATENCY(2), .COUNT_WIDTH(AW)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  memory_blank_verify #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PATTERN(PAT),
    .LAST_ADDRESS(3), .READ_LATENCY(2), .COUNT_WIDTH(2)
  ) u_sat (
    .clk(clk), .reset(reset), .bus(sat_bus)
  );

  int          n_checks;
  int          n_errors;
  logic [31:0] mem [0:2047];
  logic [31:0] rd_q;
  int          exp_addr_q[$];
  res_t        res_q[$];
  int unsigned edge_idx;
  bit          mon_en;
  bit          pause_mode;
  logic [AW-1:0] prev_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The SRAM model: address registered by the DUT, plus one data stage. That gives a latency of 2. The model freezes while paused.
  always @(posedge clk) begin
    if (!bus.pause) rd_q <= mem[bus.address[10:0]];
  end
  assign bus.data_read     = bus.pause ? 32'hDEAD_BEEF : rd_q;
  assign sat_bus.data_read = 32'h0000_0000;
  assign sat_bus.pause     = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pause pattern: 10 paused edges out of every 100, counted from enable; the first edge is never paused.
  always @(negedge clk) begin
    if (pause_mode && mon_en) bus.pause = ((edge_idx % 100) >= 90);
    else                      bus.pause = 1'b0;
  end

  // Address monitor: one issue per pause-free edge after the IDLE edge, address frozen while paused.
  always @(posedge clk) begin : mon
    logic p;
    p = bus.pause;
    edge_idx++;
    #1;
    if (mon_en && edge_idx >= 2) begin
      if (p) check_eq("addr_hold", bus.address, prev_addr);
      else if (exp_addr_q.size() > 0) check_eq("addr_order", bus.address, exp_addr_q.pop_front());
    end
    prev_addr = bus.address;
  end

  function automatic int exp_cycles(input bit pm);
    int pf = 0;
    int k  = 0;
    while (pf < LAST + 4) begin
      k++;
      if (!(pm && (((k - 1) % 100) >= 90))) pf++;
    end
    return k;
  endfunction

  function automatic res_t predict(input bit pm);
    res_t r;
    r.cycles = exp_cycles(pm);
    r.err = 0; r.fea = 0; r.fed = 32'h0;
    for (int a = 0; a <= LAST; a++) begin
      if (mem[a] != PAT) begin
        if (r.err == 0) begin r.fea = a; r.fed = mem[a]; end
        if (r.err < ERR_MAX) r.err++;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic start_run(input bit pm);
    exp_addr_q.delete();
    for (int a = 0; a <= LAST; a++) exp_addr_q.push_back(a);
    res_q.push_back(predict(pm));
    @(negedge clk);
    bus.enable = 1'b1;
    edge_idx   = 0;
    mon_en     = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    res_t r;
    int   cyc = 0;
    bit   hit = 0;
    r = res_q.pop_front();
    while (cyc < r.cycles + 50 && !hit) begin
      @(posedge clk); #1;
      cyc++;
      hit = bus.done;
    end
    mon_en = 1'b0;
    check_eq({tag, "_done"},   hit, 1'b1);
    check_eq({tag, "_cycles"}, cyc, r.cycles);
    check_eq({tag, "_err"},    bus.error_count, r.err);
    check_eq({tag, "_fea"},    bus.first_error_address, r.fea);
    check_eq({tag, "_fed"},    bus.first_error_data, r.fed);
    check_eq({tag, "_pass"},   bus.pass, r.pass);
    check_eq({tag, "_left"},   exp_addr_q.size(), 0);
    check_eq({tag, "_last"},   bus.address, LAST);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_addr"}, bus.address, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_pass"}, bus.pass, 0);
    check_eq({tag, "_err"},  bus.error_count, 0);
    check_eq({tag, "_fea"},  bus.first_error_address, 0);
    check_eq({tag, "_fed"},  bus.first_error_data, 0);
    check_eq({tag, "_wren"}, bus.wren, 0);
  endtask

  task automatic wait_addr(input int a, input string tag);
    int c   = 0;
    bit hit = 0;
    while (c < LAST + 200 && !hit) begin
      @(posedge clk); #1;
      c++;
      hit = (bus.address == a);
    end
    check_eq(tag, hit, 1'b1);
  endtask

  task automatic stop_run(input string tag);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check_idle(tag);
  endtask

  initial begin
    int cyc;
    bit hit;
    n_checks = 0; n_errors = 0;
    mon_en = 1'b0; pause_mode = 1'b0; edge_idx = 0;
    bus.enable = 1'b0; sat_bus.enable = 1'b0;
    reset = 1'b1;
    for (int a = 0; a < 2048; a++) mem[a] = PAT;

    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check_eq("rst_sat_err", sat_bus.error_count, 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("idle_no_en");

    // Clean memory, no pause.
    start_run(1'b0);
    wait_done("t1");
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("t1_hold_done", bus.done, 1);
      check_eq("t1_hold_addr", bus.address, LAST);
    end
    stop_run("t1_clr");

    // Clean memory with periodic pause.
    pause_mode = 1'b1;
    start_run(1'b1);
    wait_done("t3");
    pause_mode = 1'b0;
    stop_run("t3_clr");

    // Two blanked words read back as zero.
    mem[5] = 32'h0; mem[1000] = 32'h0;
    start_run(1'b0);
    wait_done("t2");
    stop_run("t2_clr");

    // Abort mid-run at address 500, restart three cycles later.
    start_run(1'b0);
    wait_addr(500, "t4_reach");
    @(negedge clk);
    bus.enable = 1'b0; mon_en = 1'b0; res_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("t4_low");
    end
    start_run(1'b0);
    wait_done("t4_rerun");
    stop_run("t4_clr");

    // Asynchronous reset between edges mid-run.
    start_run(1'b0);
    wait_addr(600, "t5_reach");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_idle("t5_async");
    bus.enable = 1'b0; mon_en = 1'b0; res_q.delete();
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_idle("t5_idle");
    end
    start_run(1'b0);
    wait_done("t5_rerun");
    stop_run("t5_clr");

    // Four addresses, every word wrong, 2-bit counter saturates at 3.
    @(negedge clk); sat_bus.enable = 1'b1;
    cyc = 0; hit = 0;
    while (cyc < 40 && !hit) begin
      @(posedge clk); #1;
      cyc++;
      hit = sat_bus.done;
    end
    check_eq("t6_done",   hit, 1'b1);
    check_eq("t6_cycles", cyc, 7);
    check_eq("t6_err",    sat_bus.error_count, 3);
    check_eq("t6_fea",    sat_bus.first_error_address, 0);
    check_eq("t6_fed",    sat_bus.first_error_data, 0);
    check_eq("t6_pass",   sat_bus.pass, 0);
    check_eq("t6_addr",   sat_bus.address, 3);
    @(negedge clk); sat_bus.enable = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_clr_err",  sat_bus.error_count, 0);
    check_eq("t6_clr_done", sat_bus.done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
